// File: rtl/mod31_timer_pkg.sv
// Shared definitions for the mod-31 period timer: state encodings, count width
// and the terminal state value of the modulo-31 sequence.
package mod31_timer_pkg;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] MOD_MAX = 5'd30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod31_next_state.sv
// Combinational successor for the modulo-31 count: wraps 30 to 0 and folds the
// unreachable code 31 back to 0.
module mod31_next_state
    import mod31_timer_pkg::*;
(
    input  logic [CNT_W-1:0] q_i,
    output logic [CNT_W-1:0] nxt_o
);

    always_comb begin
        nxt_o = (q_i >= MOD_MAX) ? '0 : q_i + 5'd1;
    end

endmodule

// File: rtl/mod31_timer.sv
// Programmable period timer on a modulo-31 count with terminal-count pulse,
// sticky interrupt, and one-shot or periodic operation.
module mod31_timer
    import mod31_timer_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             oneshot_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             irq_ack_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o,
    output logic             irq_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             oneshot_q, oneshot_d;
    logic             tc_q, tc_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] countNxt;

    mod31_next_state u_next (
        .q_i   (count_q),
        .nxt_o (countNxt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            period_q  <= '0;
            oneshot_q <= 1'b0;
            tc_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            tc_q      <= tc_d;
            irq_q     <= irq_d;
        end
    end

    // Priority: stop, then start, then terminal match, then plain increment.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        tc_d      = 1'b0;

        if (stop_i) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start_i) begin
            period_d  = (period_i > MOD_MAX) ? MOD_MAX : period_i;
            oneshot_d = oneshot_i;
            count_d   = '0;
            state_d   = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: count_d = '0;
                ST_RUN: begin
                    if (count_q == period_q) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                        if (oneshot_q) state_d = ST_DONE;
                    end else begin
                        count_d = countNxt;
                    end
                end
                ST_DONE: count_d = '0;
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end

        // A terminal count on the same edge as an acknowledge keeps irq set.
        if (tc_d)           irq_d = 1'b1;
        else if (irq_ack_i) irq_d = 1'b0;
        else                irq_d = irq_q;
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign irq_o   = irq_q;
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_mod31_timer.sv
// Directed self-checking bench for mod31_timer, plus a unit check of the
// modulo-31 successor logic.
module tb_mod31_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       startIn, stopIn, oneshotIn, irqAck;
    logic [4:0] periodIn;
    logic [4:0] countOut;
    logic       tcOut, irqOut, busyOut, doneOut;
    logic [4:0] utQ, utNxt;

    int checkCount = 0;
    int failCount  = 0;

    mod31_timer dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (startIn),
        .stop_i    (stopIn),
        .oneshot_i (oneshotIn),
        .period_i  (periodIn),
        .irq_ack_i (irqAck),
        .count_o   (countOut),
        .tc_o      (tcOut),
        .irq_o     (irqOut),
        .busy_o    (busyOut),
        .done_o    (doneOut)
    );

    mod31_next_state utNext (
        .q_i   (utQ),
        .nxt_o (utNxt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic os,
                                 input logic [4:0] per, input logic ack);
        startIn   = s;
        stopIn    = p;
        oneshotIn = os;
        periodIn  = per;
        irqAck    = ack;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [4:0] c, input logic t,
                            input logic i, input logic b, input logic d);
        checkOutput({tag, ".count"}, countOut, c);
        checkOutput({tag, ".tc"},    tcOut,    t);
        checkOutput({tag, ".irq"},   irqOut,   i);
        checkOutput({tag, ".busy"},  busyOut,  b);
        checkOutput({tag, ".done"},  doneOut,  d);
    endtask

    initial begin
        rst = 1'b1;
        utQ = 5'd0;
        applyStimulus(0, 0, 0, 5'd0, 0);
        tick();
        tick();
        checkAll("reset", 5'd0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Reset mid-count at 7.
        applyStimulus(1, 0, 0, 5'd20, 0);
        tick();
        applyStimulus(0, 0, 0, 5'd20, 0);
        for (int k = 1; k <= 7; k++) tick();
        checkOutput("midrun.count7", countOut, 5'd7);
        rst = 1'b1;
        #1;
        checkAll("asyncReset", 5'd0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        checkAll("postReset", 5'd0, 0, 0, 0, 0);

        // Periodic P=5; period change while running must be ignored.
        applyStimulus(1, 0, 0, 5'd5, 0);
        tick();
        checkAll("per5.E0", 5'd0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 5'd2, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput($sformatf("per5.count%0d", k), countOut, k[4:0]);
            checkOutput($sformatf("per5.tc%0d", k), tcOut, 1'b0);
        end
        tick();
        checkAll("per5.tc1", 5'd0, 1, 1, 1, 0);
        applyStimulus(0, 0, 1, 5'd2, 1);
        tick();
        checkAll("per5.ack", 5'd1, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 5'd2, 0);
        for (int k = 2; k <= 5; k++) tick();
        checkAll("per5.count5b", 5'd5, 0, 0, 1, 0);
        tick();
        checkAll("per5.tc2", 5'd0, 1, 1, 1, 0);
        applyStimulus(0, 0, 1, 5'd2, 1);
        tick();
        checkOutput("per5.ack2", irqOut, 1'b0);
        applyStimulus(0, 0, 1, 5'd2, 0);
        for (int k = 2; k <= 5; k++) tick();
        applyStimulus(0, 0, 1, 5'd2, 1);
        tick();
        checkAll("ackOnTc", 5'd0, 1, 1, 1, 0);
        applyStimulus(0, 0, 1, 5'd2, 0);
        tick();
        checkAll("ackOnTc.after", 5'd1, 0, 1, 1, 0);

        // One-shot with period 31 clipped to 30; restart at count 12.
        applyStimulus(1, 0, 1, 5'd31, 1);
        tick();
        checkAll("clip.E0", 5'd0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 5'd31, 0);
        for (int k = 1; k <= 12; k++) tick();
        checkOutput("clip.count12", countOut, 5'd12);
        applyStimulus(1, 0, 1, 5'd31, 0);
        tick();
        checkAll("restart", 5'd0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 5'd3, 0);
        for (int k = 1; k <= 30; k++) tick();
        checkAll("clip.count30", 5'd30, 0, 0, 1, 0);
        tick();
        checkAll("oneshot.tc", 5'd0, 1, 1, 0, 1);
        tick();
        checkAll("oneshot.hold", 5'd0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 5'd3, 1);
        tick();
        checkAll("oneshot.ack", 5'd0, 0, 0, 0, 1);

        // Period 0, periodic: tc every RUN cycle, then stop.
        applyStimulus(1, 0, 0, 5'd0, 0);
        tick();
        checkAll("p0.E0", 5'd0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 5'd0, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checkAll($sformatf("p0.tc%0d", k), 5'd0, 1, 1, 1, 0);
        end
        applyStimulus(0, 1, 0, 5'd0, 0);
        tick();
        checkAll("p0.stop", 5'd0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 5'd0, 1);
        tick();
        checkAll("idle.ack", 5'd0, 0, 0, 0, 0);

        // Period 0, one-shot: single tc then DONE.
        applyStimulus(1, 0, 1, 5'd0, 0);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 0);
        tick();
        checkAll("p0os.tc", 5'd0, 1, 1, 0, 1);
        tick();
        checkAll("p0os.hold", 5'd0, 0, 1, 0, 1);

        // Stop outranks start.
        applyStimulus(1, 1, 0, 5'd4, 0);
        tick();
        checkAll("stopOverStart", 5'd0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 5'd0, 0);

        // Successor logic unit vectors.
        utQ = 5'd29; #1; checkOutput("nxt29", utNxt, 5'd30);
        utQ = 5'd30; #1; checkOutput("nxt30", utNxt, 5'd0);
        utQ = 5'd31; #1; checkOutput("nxt31", utNxt, 5'd0);
        utQ = 5'd0;  #1; checkOutput("nxt0",  utNxt, 5'd1);
        utQ = 5'd15; #1; checkOutput("nxt15", utNxt, 5'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
